// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier for MULT/MULTU
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   select       command: 01 = load, 10 = step, 00/11 = hold
//   multiplicand operand A, sampled on load
//   multiplier   operand B, sampled on load
//   hi, lo       registered product halves, updated only on load (cleared) or completion
//   busy         high from the load edge until the final step edge
//   done         high after completion until the next load or reset
module seq_multiplier #(
    parameter int SIGN  = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               negative;

    // Operand magnitudes. The most-negative value negates to itself, which
    // read as unsigned is already the correct magnitude.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign a_neg = (SIGN != 0) && multiplicand[WIDTH-1];
    assign b_neg = (SIGN != 0) && multiplier[WIDTH-1];
    assign abs_a = a_neg ? -multiplicand : multiplicand;
    assign abs_b = b_neg ? -multiplier : multiplier;

    // Accumulator value after the current step, and the signed-corrected
    // product used on the final step.
    logic [2*WIDTH-1:0] acc_new;
    logic [2*WIDTH-1:0] product;

    assign acc_new = mplier[0] ? (acc + mcand) : acc;
    assign product = negative ? -acc_new : acc_new;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            negative <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (select == 2'b01) begin
            // Load restarts unconditionally, even mid-operation.
            state    <= RUN;
            count    <= CW'(WIDTH);
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, abs_a};
            mplier   <= abs_b;
            negative <= a_neg ^ b_neg;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (select == 2'b10 && state == RUN) begin
            acc    <= acc_new;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
            if (count == CW'(1)) begin
                hi    <= product[2*WIDTH-1:WIDTH];
                lo    <= product[WIDTH-1:0];
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  select;
    logic [31:0] a;
    logic [31:0] b;

    logic [31:0] hi_s, lo_s, hi_u, lo_u;
    logic        busy_s, done_s, busy_u, done_u;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.SIGN(1), .WIDTH(32)) u_signed (
        .clk          (clk),
        .reset_n      (reset_n),
        .select       (select),
        .multiplicand (a),
        .multiplier   (b),
        .hi           (hi_s),
        .lo           (lo_s),
        .busy         (busy_s),
        .done         (done_s)
    );

    seq_multiplier #(.SIGN(0), .WIDTH(32)) u_unsigned (
        .clk          (clk),
        .reset_n      (reset_n),
        .select       (select),
        .multiplicand (a),
        .multiplier   (b),
        .hi           (hi_u),
        .lo           (lo_u),
        .busy         (busy_u),
        .done         (done_u)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply a command for one rising edge, then settle 1ns past it.
    task automatic tick(input logic [1:0] sel);
        select = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) tick(2'b10);
        select = 2'b00;
    endtask

    task automatic load(input logic [31:0] av, input logic [31:0] bv);
        a = av;
        b = bv;
        tick(2'b01);
        select = 2'b00;
    endtask

    initial begin
        reset_n = 1'b0;
        select  = 2'b00;
        a       = '0;
        b       = '0;
        tick(2'b01);
        tick(2'b00);
        check("reset_prod", {hi_s, lo_s}, 64'd0);
        check("reset_flags", {62'd0, busy_s, done_s}, 64'd0);
        reset_n = 1'b1;

        // 7 * 6 with completion timing
        load(32'd7, 32'd6);
        check("load_busy", {62'd0, busy_s, done_s}, {62'd0, 2'b10});
        steps(31);
        check("step31_flags", {62'd0, busy_s, done_s}, {62'd0, 2'b10});
        check("step31_prod", {hi_s, lo_s}, 64'd0);
        steps(1);
        check("step32_flags", {62'd0, busy_s, done_s}, {62'd0, 2'b01});
        check("7x6", {hi_s, lo_s}, 64'h00000000_0000002A);
        check("7x6_unsigned", {hi_u, lo_u}, 64'h00000000_0000002A);

        // -3 * 5
        load(32'hFFFFFFFD, 32'd5);
        steps(32);
        check("m3x5", {hi_s, lo_s}, 64'hFFFFFFFF_FFFFFFF1);

        // most-negative squared
        load(32'h80000000, 32'h80000000);
        steps(32);
        check("minxmin", {hi_s, lo_s}, 64'h40000000_00000000);
        check("minxmin_unsigned", {hi_u, lo_u}, 64'h40000000_00000000);

        // all ones: unsigned vs signed
        load(32'hFFFFFFFF, 32'hFFFFFFFF);
        steps(32);
        check("ffxff_unsigned", {hi_u, lo_u}, 64'hFFFFFFFE_00000001);
        check("ffxff_signed", {hi_s, lo_s}, 64'h00000000_00000001);

        // pause mid-run
        load(32'h12345678, 32'hFFFFFFFE);
        steps(16);
        for (int i = 0; i < 10; i++) tick(2'b00);
        check("pause_prod", {hi_s, lo_s}, 64'd0);
        check("pause_flags", {62'd0, busy_s, done_s}, {62'd0, 2'b10});
        tick(2'b11);
        steps(15);
        check("pause_not_done", {62'd0, busy_s, done_s}, {62'd0, 2'b10});
        steps(1);
        check("pause_result", {hi_s, lo_s}, 64'hFFFFFFFF_DB975310);

        // reload mid-run
        load(32'd9, 32'd9);
        steps(5);
        load(32'd4, 32'hFFFFFFFC);
        check("reload_clear", {hi_s, lo_s}, 64'd0);
        steps(32);
        check("reload_result", {hi_s, lo_s}, 64'hFFFFFFFF_FFFFFFF0);
        steps(3);
        check("extra_steps_prod", {hi_s, lo_s}, 64'hFFFFFFFF_FFFFFFF0);
        check("extra_steps_flags", {62'd0, busy_s, done_s}, {62'd0, 2'b01});

        // async reset mid-run
        load(32'd7, 32'd6);
        steps(20);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_prod", {hi_s, lo_s}, 64'd0);
        check("async_rst_flags", {62'd0, busy_s, done_s}, 64'd0);
        tick(2'b00);
        #2;
        reset_n = 1'b1;
        steps(40);
        check("post_rst_prod", {hi_s, lo_s}, 64'd0);
        check("post_rst_flags", {62'd0, busy_s, done_s}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative shift-add multiplier; the inverse operation of the team's iterative divider, used by the same ALU control FSM for MULT/MULTU.
- Uses the same select-driven protocol: a load command, then one step per clock.
- Produces a 64-bit product split into hi/lo, and flags completion so the control FSM can write HI/LO.

Parameters:
- SIGN, 1: 1 = two's-complement operands and product; 0 = unsigned.
- WIDTH, 32: operand width; the product is 2*WIDTH. Only 32 is required to be verified.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- select  in  2  command: 2'b01 = load, 2'b10 = step, 2'b00/2'b11 = hold.
- multiplicand  in  32  operand A; sampled only on load.
- multiplier  in  32  operand B; sampled only on load.
- hi  out  32  product bits [63:32]; registered.
- lo  out  32  product bits [31:0]; registered.
- busy  out  1  high from the load edge until the final step edge.
- done  out  1  high after completion, until the next load or reset.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset (reset_n=0, asynchronous): hi=0, lo=0, busy=0, done=0. All internal state is cleared: state=IDLE, count=0, acc=0, negative flag=0.
- States: IDLE, RUN, DONE.
- Load (select=01 at a clk edge, from any state):
  - count=32; acc(64)=0; hi=lo=0; busy=1; done=0; state=RUN.
  - mcand(64) = {32'd0, |A|}; mplier(32) = |B|.
  - |x| = x when SIGN=0 or x[31]=0; otherwise ~x+1.
  - negative = SIGN & (A[31]^B[31]).
  - Load always wins, including mid-operation; this is a restart.
- Step (select=10 at a clk edge, state=RUN):
  - if mplier[0], acc = acc + mcand.
  - then mcand <<= 1; mplier >>= 1; count = count - 1.
- Completion: on the step edge where count goes 1->0:
  - {hi,lo} = negative ? (~acc_new+1) : acc_new, where acc_new includes that step's add.
  - busy=0; done=1; state=DONE.
- Latency: 1 load edge + 32 step edges. done is visible after the 32nd step edge. Steps need not be consecutive.
- Hold (select=00 or 11): all registers keep their values. A pause mid-RUN is legal and must not corrupt the result.
- Ignored steps: select=10 in IDLE or DONE is a no-op; hi/lo/done are held.
- hi/lo change only on load (cleared) or completion; they never show partial sums.
- Most-negative operand: 0x80000000 negates to itself; zero-extended, it is the correct magnitude 2^31. No special case is needed.
- Overflow: none. The 64-bit accumulator holds the full 32x32 product; the maximum magnitude is 2^62 signed or (2^32-1)^2 unsigned.
- Zero operands: follow the normal path; the result is 0 and the negative flag is irrelevant (negating 0 gives 0).
- Reset asserted mid-RUN: everything is cleared immediately. After release, the block is in IDLE and needs a fresh load.
- Reset released: the first edge behaves per select; a load is honoured on that first edge.

Test Plan:
- SIGN=1, A=7, B=6: load, 32 steps -> hi=0x00000000, lo=0x0000002A; done=1 exactly after the 32nd step edge; busy=1 during RUN.
- SIGN=1, A=-3 (0xFFFFFFFD), B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then A=0x80000000, B=0x80000000 -> hi=0x40000000, lo=0x00000000.
- SIGN=0, A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. With SIGN=1, the same operands -> hi=0, lo=1.
- SIGN=1, A=0x12345678, B=-2: insert 10 hold cycles (select=00) after step 16, then finish -> hi=0xFFFFFFFF, lo=0xDB975310. hi/lo stay 0 through the pause.
- Reload mid-run: A=9, B=9, 5 steps, then load A=4, B=-4, 32 steps -> lo=0xFFFFFFF0, hi=0xFFFFFFFF. Extra select=10 edges after done leave the result unchanged.
- Pull reset_n low asynchronously at step 20 (between edges) -> hi=lo=0, busy=done=0 immediately. After release, with no load, 40 step edges leave the outputs at 0.
